// File: rtl/rmap_pkg.sv
// Shared RMAP protocol constants, FSM encodings and the CRC-8 table/update helpers.
// The RMAP_PATH_ADDR_EN build option selects the path-address prefix; it is described in rmap_cmd_encoder.sv.
package rmap_pkg;

  localparam logic [7:0] PROTOCOL_ID  = 8'h01;
  localparam logic [1:0] PKT_TYPE_CMD = 2'b01;

  localparam int INSTR_WRITE_BIT  = 5;
  localparam int INSTR_VERIFY_BIT = 4;
  localparam int INSTR_REPLY_BIT  = 3;
  localparam int INSTR_INC_BIT    = 2;

  localparam logic [8:0] EOP = 9'h100;
  localparam logic [8:0] EEP = 9'h101;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PATH = 3'd1;
  localparam state_t ST_HDR  = 3'd2;
  localparam state_t ST_HCRC = 3'd3;
  localparam state_t ST_DATA = 3'd4;
  localparam state_t ST_DCRC = 3'd5;
  localparam state_t ST_EOP  = 3'd6;

  // Reflected form of x^8+x^2+x+1, data fed LSB first (table[1] = 0x91).
  function automatic logic [255:0][7:0] gen_crc_table();
    logic [255:0][7:0] t;
    logic [7:0]        c;
    for (int i = 0; i < 256; i++) begin
      c = 8'(i);
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 8'hE0) : (c >> 1);
      end
      t[i] = c;
    end
    return t;
  endfunction

  localparam logic [255:0][7:0] CRC_TABLE = gen_crc_table();

  function automatic logic [7:0] crc8(input logic [7:0] crc, input logic [7:0] data);
    return CRC_TABLE[crc ^ data];
  endfunction

  function automatic logic [7:0] instr_byte(input logic w, input logic v, input logic r,
                                            input logic inc, input logic [1:0] ral_words);
    logic [7:0] b;
    b                   = {PKT_TYPE_CMD, 6'b0};
    b[INSTR_WRITE_BIT]  = w;
    b[INSTR_VERIFY_BIT] = v;
    b[INSTR_REPLY_BIT]  = r;
    b[INSTR_INC_BIT]    = inc;
    b[1:0]              = ral_words;
    return b;
  endfunction

endpackage

// File: rtl/rmap_crc8.sv
// Byte-wise RMAP CRC-8 register; init reseeds to zero and takes priority over enable.
module rmap_crc8
  import rmap_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] crc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= 8'h00;
    end else if (init_i) begin
      crc_q <= 8'h00;
    end else if (en_i) begin
      crc_q <= crc8(crc_q, data_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/rmap_cmd_encoder.sv
// RMAP command packet builder writing {flag, byte} words into the SpaceWire TX FIFO.
// Build option RMAP_PATH_ADDR_EN adds a path-address prefix that is kept out of the header CRC.
//
// state | meaning
// IDLE  | waiting for start
// PATH  | emitting path-address prefix bytes
// HDR   | emitting header bytes, index 0..14+replyAddrLen
// HCRC  | emitting header CRC, reseeding the CRC for data
// DATA  | forwarding write data bytes, down-counter on length
// DCRC  | emitting data CRC
// EOP   | emitting EOP (or EEP after abort), then done
module rmap_cmd_encoder
  import rmap_pkg::*;
#(
  parameter int MAX_DATA_LEN = 256
`ifdef RMAP_PATH_ADDR_EN
  , parameter int PATH_MAX = 4
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          cmdWrite,
  input  logic          cmdVerify,
  input  logic          cmdReply,
  input  logic          cmdIncrement,
  input  logic [7:0]    key,
  input  logic [7:0]    targLogAddr,
  input  logic [7:0]    initLogAddr,
  input  logic [15:0]   transID,
  input  logic [7:0]    extAddr,
  input  logic [31:0]   addr,
  input  logic [23:0]   dataLen,
  input  logic [95:0]   replyAddr,
  input  logic [3:0]    replyAddrLen,
`ifdef RMAP_PATH_ADDR_EN
  input  logic [8*PATH_MAX-1:0] pathAddr,
  input  logic [2:0]    pathLen,
`endif
  input  logic          abort,
  input  logic [7:0]    dataByte,
  input  logic          dataValid,
  output logic          dataReady,
  output logic          txWriteEnable,
  output logic [8:0]    txDataIn,
  input  logic          txFull,
  output logic          busy,
  output logic          done,
  output logic          cmdInvalid
);

  state_t          state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [4:0]      hdr_last_q, hdr_last_d;
  logic [26:0][7:0] hdr_q, hdr_d;
  logic [23:0]     cnt_q, cnt_d;
  logic            write_q, write_d;
  logic            eep_q, eep_d;
  logic            done_q, done_d;
  logic            inv_q, inv_d;

  logic            crc_init, crc_en;
  logic [7:0]      crc_data, crc_val;
  logic            wr;
  logic [8:0]      wdata;
  logic            ready;
  logic            start_ok;
  logic            ral_ok, len_ok, path_ok;
  logic [183:0]    body, body_sh;
  logic [7:0]      hdr_byte;

`ifdef RMAP_PATH_ADDR_EN
  logic [PATH_MAX-1:0][7:0] path_q, path_d;
  logic [2:0]      pidx_q, pidx_d;
  logic [2:0]      plen_q, plen_d;

  assign path_ok = (32'(pathLen) <= PATH_MAX);
`else
  assign path_ok = 1'b1;
`endif

  assign ral_ok   = (replyAddrLen == 4'd0) || (replyAddrLen == 4'd4) ||
                    (replyAddrLen == 4'd8) || (replyAddrLen == 4'd12);
  assign len_ok   = !cmdWrite || (dataLen <= 24'(MAX_DATA_LEN));
  assign start_ok = ral_ok && len_ok && path_ok;

  // Left-justify so only the last replyAddrLen reply bytes precede the fixed tail.
  assign body    = {replyAddr, initLogAddr, transID, extAddr, addr, dataLen};
  assign body_sh = body << (8 * (32'd12 - 32'(replyAddrLen)));

  assign hdr_byte = hdr_q[5'd26 - idx_q];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hdr_last_d = hdr_last_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    eep_d      = eep_q;
    done_d     = 1'b0;
    inv_d      = 1'b0;
    crc_init   = 1'b0;
    crc_en     = 1'b0;
    crc_data   = 8'h00;
    wr         = 1'b0;
    wdata      = 9'h000;
    ready      = 1'b0;
`ifdef RMAP_PATH_ADDR_EN
    path_d     = path_q;
    pidx_d     = pidx_q;
    plen_d     = plen_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            hdr_d      = {targLogAddr, PROTOCOL_ID,
                          instr_byte(cmdWrite, cmdVerify, cmdReply, cmdIncrement, replyAddrLen[3:2]),
                          key, body_sh};
            hdr_last_d = 5'd14 + {1'b0, replyAddrLen};
            idx_d      = 5'd0;
            cnt_d      = dataLen;
            write_d    = cmdWrite;
            eep_d      = 1'b0;
            crc_init   = 1'b1;
`ifdef RMAP_PATH_ADDR_EN
            path_d     = pathAddr << (8 * (PATH_MAX - 32'(pathLen)));
            pidx_d     = 3'd0;
            plen_d     = pathLen;
            state_d    = (pathLen != 3'd0) ? ST_PATH : ST_HDR;
`else
            state_d    = ST_HDR;
`endif
          end else begin
            inv_d = 1'b1;
          end
        end
      end
`ifdef RMAP_PATH_ADDR_EN
      ST_PATH: begin
        wdata = {1'b0, path_q[PATH_MAX-1]};
        if (!txFull) begin
          wr     = 1'b1;
          path_d = path_q << 8;
          pidx_d = pidx_q + 3'd1;
          if (pidx_q + 3'd1 == plen_q) state_d = ST_HDR;
        end
      end
`endif
      ST_HDR: begin
        wdata = {1'b0, hdr_byte};
        if (!txFull) begin
          wr       = 1'b1;
          crc_en   = 1'b1;
          crc_data = hdr_byte;
          idx_d    = idx_q + 5'd1;
          if (idx_q == hdr_last_q) state_d = ST_HCRC;
        end
      end
      ST_HCRC: begin
        wdata = {1'b0, crc_val};
        if (!txFull) begin
          wr       = 1'b1;
          crc_init = 1'b1;
          if (!write_q)             state_d = ST_EOP;
          else if (cnt_q == 24'd0)  state_d = ST_DCRC;
          else                      state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        ready = !txFull;
        wdata = {1'b0, dataByte};
        if (dataValid && !txFull) begin
          wr       = 1'b1;
          crc_en   = 1'b1;
          crc_data = dataByte;
          cnt_d    = cnt_q - 24'd1;
          if (cnt_q == 24'd1) state_d = ST_DCRC;
        end
      end
      ST_DCRC: begin
        wdata = {1'b0, crc_val};
        if (!txFull) begin
          wr      = 1'b1;
          state_d = ST_EOP;
        end
      end
      ST_EOP: begin
        wdata = eep_q ? EEP : EOP;
        if (!txFull) begin
          wr      = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Once the terminator state is reached the normal EOP stands even if abort arrives.
    if (abort && (state_q != ST_IDLE) && (state_q != ST_EOP)) begin
      state_d = ST_EOP;
      eep_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= 5'd0;
      hdr_last_q <= 5'd0;
      hdr_q      <= '0;
      cnt_q      <= 24'd0;
      write_q    <= 1'b0;
      eep_q      <= 1'b0;
      done_q     <= 1'b0;
      inv_q      <= 1'b0;
`ifdef RMAP_PATH_ADDR_EN
      path_q     <= '0;
      pidx_q     <= 3'd0;
      plen_q     <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hdr_last_q <= hdr_last_d;
      hdr_q      <= hdr_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      eep_q      <= eep_d;
      done_q     <= done_d;
      inv_q      <= inv_d;
`ifdef RMAP_PATH_ADDR_EN
      path_q     <= path_d;
      pidx_q     <= pidx_d;
      plen_q     <= plen_d;
`endif
    end
  end

  rmap_crc8 u_crc (
    .clk    (clk),
    .rst    (rst),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (crc_data),
    .crc_o  (crc_val)
  );

  assign txWriteEnable = wr;
  assign txDataIn      = wr ? wdata : 9'h000;
  assign dataReady     = ready;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign cmdInvalid    = inv_q;

endmodule

// File: tb/tb_rmap_cmd_encoder.sv
// Directed bench for rmap_cmd_encoder: packets are captured from the FIFO port and
// compared against hand-written byte lists with CRCs from a bitwise reference.
module tb_rmap_cmd_encoder;

  logic         clk;
  logic         rst;
  logic         start;
  logic         cmdWrite, cmdVerify, cmdReply, cmdIncrement;
  logic [7:0]   key, targLogAddr, initLogAddr, extAddr;
  logic [15:0]  transID;
  logic [31:0]  addr;
  logic [23:0]  dataLen;
  logic [95:0]  replyAddr;
  logic [3:0]   replyAddrLen;
`ifdef RMAP_PATH_ADDR_EN
  logic [31:0]  pathAddr;
  logic [2:0]   pathLen;
`endif
  logic         abort;
  logic [7:0]   dataByte;
  logic         dataValid;
  logic         dataReady;
  logic         txWriteEnable;
  logic [8:0]   txDataIn;
  logic         txFull;
  logic         busy, done, cmdInvalid;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  logic [8:0] log_q [$];
  logic [8:0] exp_q [$];
  logic [7:0] wdat [$];
  logic [7:0] hdr_b [$];
  int n_full_wr, n_rdy_full, n_ready_seen, n_done, n_inv, n_busy_seen, n_term;
  bit to;

  rmap_cmd_encoder dut (
    .clk(clk), .rst(rst), .start(start),
    .cmdWrite(cmdWrite), .cmdVerify(cmdVerify), .cmdReply(cmdReply), .cmdIncrement(cmdIncrement),
    .key(key), .targLogAddr(targLogAddr), .initLogAddr(initLogAddr), .transID(transID),
    .extAddr(extAddr), .addr(addr), .dataLen(dataLen), .replyAddr(replyAddr),
    .replyAddrLen(replyAddrLen),
`ifdef RMAP_PATH_ADDR_EN
    .pathAddr(pathAddr), .pathLen(pathLen),
`endif
    .abort(abort), .dataByte(dataByte), .dataValid(dataValid), .dataReady(dataReady),
    .txWriteEnable(txWriteEnable), .txDataIn(txDataIn), .txFull(txFull),
    .busy(busy), .done(done), .cmdInvalid(cmdInvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (txWriteEnable) log_q.push_back(txDataIn);
    if (txWriteEnable && txDataIn[8]) n_term++;
    if (txWriteEnable && txFull) n_full_wr++;
    if (dataReady && txFull) n_rdy_full++;
    if (dataReady) n_ready_seen++;
    if (done) n_done++;
    if (cmdInvalid) n_inv++;
    if (busy) n_busy_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_crc(input logic [7:0] b [$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb = c[0] ^ b[i][k];
        c  = c >> 1;
        if (fb) c = c ^ 8'hE0;
      end
    end
    return c;
  endfunction

  task automatic add_bytes(input logic [7:0] b [$], input bit with_crc);
    foreach (b[i]) exp_q.push_back({1'b0, b[i]});
    if (with_crc) exp_q.push_back({1'b0, ref_crc(b)});
  endtask

  task automatic check_pkt(input string tag);
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_w%0d", tag, i),
            32'((i < log_q.size()) ? log_q[i] : 9'h1FF), 32'(exp_q[i]));
    end
  endtask

  task automatic clear_mon();
    log_q.delete();
    exp_q.delete();
    n_full_wr = 0; n_rdy_full = 0; n_ready_seen = 0; n_done = 0;
    n_inv = 0; n_busy_seen = 0; n_term = 0;
  endtask

  task automatic set_wr_cmd(input logic [23:0] len);
    cmdWrite = 1'b1; cmdVerify = 1'b1; cmdReply = 1'b1; cmdIncrement = 1'b0;
    key = 8'h20; targLogAddr = 8'hFE; initLogAddr = 8'hFE; transID = 16'h4567;
    extAddr = 8'h00; addr = 32'h0000_0004; dataLen = len;
    replyAddr = 96'hDEADBEEF_01234567_89ABCDEF; replyAddrLen = 4'd0;
  endtask

  // Caller is at posedge+1; returns at posedge+1 of the cycle after start.
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input bit rnd, input int abort_at, output bit timed_out);
    int  di;
    int  cyc;
    bit  aborted;
    bit  fin;
    di = 0; cyc = 0; aborted = 0; fin = 0; timed_out = 0;
    while (!fin) begin
      txFull    = rnd && ($urandom_range(0, 2) == 0);
      dataValid = 1'b0;
      abort     = 1'b0;
      if (abort_at >= 0 && di == abort_at && !aborted) begin
        abort   = 1'b1;
        aborted = 1;
      end else if (di < wdat.size()) begin
        dataValid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        dataByte  = wdat[di];
      end
      @(negedge clk);
      if (dataValid && dataReady) di++;
      if (done) fin = 1;
      cyc++;
      if (cyc > 600) begin
        timed_out = 1;
        fin = 1;
      end
      @(posedge clk); #1;
    end
    txFull = 1'b0; dataValid = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; txFull = 1'b0;
    dataValid = 1'b0; dataByte = 8'h00;
`ifdef RMAP_PATH_ADDR_EN
    pathAddr = 32'h0; pathLen = 3'd0;
`endif
    set_wr_cmd(24'd4);
    clear_mon();

    // reset state
    @(negedge clk);
    check("reset_outputs",
          32'({txWriteEnable, txDataIn, dataReady, busy, done, cmdInvalid}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // write, 4 data bytes, FIFO always free
    hdr_b = '{8'hFE, 8'h01, 8'h78, 8'h20, 8'hFE, 8'h45, 8'h67, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h04};
    wdat  = '{8'h89, 8'hAB, 8'hCD, 8'hEF};
    set_wr_cmd(24'd4);
    clear_mon();
    do_start();
    @(negedge clk);
    check("latency_first_byte", 32'({txWriteEnable, txDataIn}), 32'({1'b1, 9'h0FE}));
    check("busy_after_start", 32'(busy), 32'd1);
    @(posedge clk); #1;
    run(0, -1, to);
    check("wr4_timeout", 32'(to), 32'd0);
    add_bytes(hdr_b, 1);
    add_bytes(wdat, 1);
    exp_q.push_back(9'h100);
    check_pkt("wr4");
    check("wr4_done", 32'(n_done), 32'd1);
    check("wr4_busy_after", 32'(busy), 32'd0);

    // same write under FIFO backpressure and data gaps
    clear_mon();
    do_start();
    run(1, -1, to);
    check("wr4bp_timeout", 32'(to), 32'd0);
    add_bytes(hdr_b, 1);
    add_bytes(wdat, 1);
    exp_q.push_back(9'h100);
    check_pkt("wr4bp");
    check("wr4bp_write_when_full", 32'(n_full_wr), 32'd0);
    check("wr4bp_ready_when_full", 32'(n_rdy_full), 32'd0);

    // read with 8-byte reply address
    cmdWrite = 1'b0; cmdVerify = 1'b0; cmdReply = 1'b1; cmdIncrement = 1'b1;
    key = 8'h20; targLogAddr = 8'hFE; initLogAddr = 8'hFE; transID = 16'h0001;
    extAddr = 8'h00; addr = 32'h0000_0100; dataLen = 24'h10;
    replyAddr = 96'hAABBCCDD_11223344_55667788; replyAddrLen = 4'd8;
    wdat.delete();
    hdr_b = '{8'hFE, 8'h01, 8'h4E, 8'h20, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
              8'h77, 8'h88, 8'hFE, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
              8'h00, 8'h00, 8'h10};
    clear_mon();
    do_start();
    run(0, -1, to);
    check("rd8_timeout", 32'(to), 32'd0);
    add_bytes(hdr_b, 1);
    exp_q.push_back(9'h100);
    check_pkt("rd8");
    check("rd8_ready_never", 32'(n_ready_seen), 32'd0);
    check("rd8_done", 32'(n_done), 32'd1);

    // write with zero data length
    set_wr_cmd(24'd0);
    hdr_b = '{8'hFE, 8'h01, 8'h78, 8'h20, 8'hFE, 8'h45, 8'h67, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00};
    clear_mon();
    do_start();
    run(0, -1, to);
    check("wr0_timeout", 32'(to), 32'd0);
    add_bytes(hdr_b, 1);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h100);
    check_pkt("wr0");

    // illegal reply address length
    set_wr_cmd(24'd4);
    cmdWrite = 1'b0; replyAddrLen = 4'd5;
    clear_mon();
    do_start();
    @(negedge clk);
    check("rej_ral_pulse", 32'(cmdInvalid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rej_ral_single", 32'(cmdInvalid), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("rej_ral_writes", 32'(log_q.size()), 32'd0);
    check("rej_ral_inv_count", 32'(n_inv), 32'd1);
    check("rej_ral_busy", 32'(n_busy_seen), 32'd0);

    // write length one over the limit
    set_wr_cmd(24'd257);
    clear_mon();
    do_start();
    @(negedge clk);
    check("rej_len_pulse", 32'(cmdInvalid), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("rej_len_writes", 32'(log_q.size()), 32'd0);
    check("rej_len_inv_count", 32'(n_inv), 32'd1);
    check("rej_len_busy", 32'(n_busy_seen), 32'd0);

    // length exactly at the limit is accepted; abort during header
    set_wr_cmd(24'd256);
    wdat.delete();
    clear_mon();
    do_start();
    @(negedge clk);
    check("len_max_accept_busy", 32'(busy), 32'd1);
    check("len_max_no_invalid", 32'(cmdInvalid), 32'd0);
    @(posedge clk); #1;
    run(0, 0, to);
    check("hdr_abort_timeout", 32'(to), 32'd0);
    exp_q.push_back(9'h0FE);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h101);
    check_pkt("hdr_abort");

    // abort after two data bytes
    set_wr_cmd(24'd4);
    hdr_b = '{8'hFE, 8'h01, 8'h78, 8'h20, 8'hFE, 8'h45, 8'h67, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h04};
    wdat  = '{8'h89, 8'hAB, 8'hCD, 8'hEF};
    clear_mon();
    do_start();
    run(0, 2, to);
    check("dat_abort_timeout", 32'(to), 32'd0);
    add_bytes(hdr_b, 1);
    exp_q.push_back(9'h089);
    exp_q.push_back(9'h0AB);
    exp_q.push_back(9'h101);
    check_pkt("dat_abort");
    check("dat_abort_done", 32'(n_done), 32'd1);
    check("dat_abort_busy", 32'(busy), 32'd0);

    // reset in the middle of the header
    clear_mon();
    do_start();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_outputs",
          32'({txWriteEnable, txDataIn, dataReady, busy, done, cmdInvalid}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("midrst_words", 32'(log_q.size()), 32'd3);
    check("midrst_no_term", 32'(n_term), 32'd0);
    check("midrst_no_done", 32'(n_done), 32'd0);

`ifdef RMAP_PATH_ADDR_EN
    // path prefix ahead of the target address, outside the header CRC
    set_wr_cmd(24'd4);
    pathAddr = 32'h0000_0305;
    pathLen  = 3'd2;
    clear_mon();
    do_start();
    run(0, -1, to);
    check("path_timeout", 32'(to), 32'd0);
    exp_q.push_back(9'h003);
    exp_q.push_back(9'h005);
    add_bytes(hdr_b, 1);
    add_bytes(wdat, 1);
    exp_q.push_back(9'h100);
    check_pkt("path");
    pathLen = 3'd0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rmap_cmd_encoder.md
Name: rmap_cmd_encoder

Overview:
- Hardware RMAP command initiator-side packet builder, byte-serial, writing into the 9-bit SpaceWire TX FIFO interface used by the RMAP target.
- Generalises the fixed 4-byte write-command assembly to read and write commands, variable data length, 0/4/8/12-byte reply address, and all instruction option bits.
- Header CRC and data CRC are computed on the fly.
- Data bytes stream in over a valid/ready handshake.

Parameters:
- MAX_DATA_LEN, 256: largest accepted data length in bytes for write commands.
- PATH_MAX, 4: maximum path-address prefix bytes (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; fields below are sampled on this cycle
- cmdWrite/cmdVerify/cmdReply/cmdIncrement  in  1 each  instruction option bits
- key  in  8  command key
- targLogAddr  in  8  target logical address
- initLogAddr  in  8  initiator logical address
- transID  in  16  transaction ID
- extAddr  in  8  extended address
- addr  in  32  memory address
- dataLen  in  24  data length in bytes
- replyAddr  in  96  reply address bytes, MSB first
- replyAddrLen  in  4  reply address length; legal values 0, 4, 8, 12
- abort  in  1  terminate the current packet with EEP
- dataByte  in  8  write data
- dataValid  in  1  dataByte is valid
- dataReady  out  1  encoder accepts dataByte this cycle
- txWriteEnable  out  1  FIFO write strobe
- txDataIn  out  9  {flag, byte}
- txFull  in  1  FIFO full
- busy  out  1  packet in progress
- done  out  1  one-cycle pulse after EOP/EEP is written
- cmdInvalid  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; CRC register 0.
- Reset asserted mid-packet: FSM returns to IDLE; no EOP or EEP is emitted.
- Instruction byte: {2'b01, cmdWrite, cmdVerify, cmdReply, cmdIncrement, replyAddrLen[3:2]}.
- Byte order from IDLE: targLogAddr, 0x01, instr, key, reply address bytes, initLogAddr, transID[15:8], transID[7:0], extAddr, addr MSB to LSB, dataLen MSB to LSB, header CRC.
  - Reply address bytes: the last replyAddrLen bytes of replyAddr.
  - Write commands continue with: dataLen data bytes, data CRC, EOP.
  - Read commands continue with: EOP directly.
- EOP = 9'h100. EEP = 9'h101.
- CRC: RMAP CRC-8, byte-wise crc' = table[crc ^ byte], seed 0.
  - Header CRC covers targLogAddr through the last dataLen byte.
  - Data CRC covers the data bytes only; CRC register is reseeded before the data phase.
- FSM states: IDLE → HDR → HCRC → (DATA → DCRC) → EOP → IDLE.
  - HDR uses a byte index counter 0..(15 + replyAddrLen − 1).
  - DATA uses a 24-bit down-counter.
- Byte write rule: at most one byte per cycle; txWriteEnable = 1 only in a cycle where txFull = 0. When txFull = 1, the FSM holds state and counters.
- Data handshake: dataReady = (state == DATA) && !txFull. A byte is transferred when dataValid && dataReady, and is written to the FIFO in that same cycle.
- Latency: first header byte is written the cycle after start, if txFull = 0.
- start while busy: ignored.
- start is rejected when replyAddrLen ∉ {0, 4, 8, 12}, or when cmdWrite = 1 and dataLen > MAX_DATA_LEN.
  - Rejection: cmdInvalid pulses the next cycle; no bytes are emitted; busy stays 0.
- dataLen = 0 on a write: header CRC, then data CRC 0x00, then EOP.
- abort while busy: the next FIFO-permitted cycle writes EEP, then done pulses. abort in IDLE is ignored.
- abort and the final EOP write in the same cycle: EOP wins; done pulses normally.
- busy = 1 from the cycle after start until the cycle done pulses.

Optional Feature:
- Macro: RMAP_PATH_ADDR_EN.
- Defined: extra ports pathAddr (8*PATH_MAX bits) and pathLen (3 bits). pathLen bytes are emitted before targLogAddr and excluded from the header CRC. A start with pathLen > PATH_MAX is rejected via cmdInvalid.
- Undefined: no such ports; the packet starts at targLogAddr.

Decomposition:
- rmap_pkg:
  - PROTOCOL_ID = 8'h01
  - instruction bit-position constants
  - EOP and EEP constants
  - 256-entry CRC table and the crc8 update function
  - FSM state enum
- Sub-module rmap_crc8: byte-wise CRC register with init/enable/data inputs, instantiated once and reseeded between the header and data phases.

Test Plan:
- Write command: addr 0x4, data 89 AB CD EF, transID 0x4567, key 0x20, targ/init 0xFE, no reply address, txFull = 0 → exactly 22 FIFO writes: FE 01 78 20 FE 45 67 00 00 00 00 04 00 00 04 hCRC 89 AB CD EF dCRC 100h. Both CRCs must equal the package crc8 results.
- Same write command with txFull randomly toggling and dataValid gaps → identical byte sequence; no write while txFull = 1; dataReady never asserted while txFull = 1.
- Read command: replyAddrLen 8, cmdReply = 1, cmdIncrement = 1, dataLen 0x10 → instruction byte 0x4E; 8 reply bytes emitted after key; header CRC followed directly by 100h; dataReady stays 0.
- replyAddrLen = 5, and separately a write with dataLen = MAX_DATA_LEN + 1 → cmdInvalid single pulse; zero FIFO writes; busy stays 0.
- abort after 2 data bytes → next written word is 101h; done pulses; busy falls. Reset applied mid-header → all outputs 0 and no EOP written.
- With RMAP_PATH_ADDR_EN and pathLen = 2, path bytes 03 05 → these two bytes precede FE; header CRC is unchanged from the no-path case.
